// File: rtl/dcache_wdata_coalesce_pipe_pkg.sv
// Shared geometry and merge-mode encodings for the dcache store-data coalescer.
package dcache_wdata_coalesce_pipe_pkg;

  localparam int unsigned NLANES     = 4;
  localparam int unsigned OFFSETBITS = 2;
  localparam int unsigned NWORDS     = 1 << OFFSETBITS;
  localparam int unsigned BYTES      = 4;
  localparam int unsigned WORDLEN    = 8 * BYTES;

  typedef enum logic {
    MergeOr   = 1'b0,
    MergePrio = 1'b1
  } merge_mode_e;

  localparam merge_mode_e MERGE_MODE = MergePrio;

endpackage

// File: rtl/dcache_byte_prio_merge.sv
// Combinational N-candidate byte select: OR of all candidates, or highest-index candidate.
module dcache_byte_prio_merge
  import dcache_wdata_coalesce_pipe_pkg::*;
#(
  parameter int unsigned N    = 4,
  parameter merge_mode_e MODE = MergePrio
) (
  input  logic [N-1:0]   cand,
  input  logic [N*8-1:0] data,
  output logic           hit,
  output logic [7:0]     byte_out,
  output logic           multi
);

  logic seen;

  always_comb begin
    hit      = |cand;
    byte_out = 8'h00;
    multi    = 1'b0;
    seen     = 1'b0;
    // Ascending scan: in priority mode the last candidate seen is the highest index.
    for (int unsigned i = 0; i < N; i++) begin
      if (cand[i]) begin
        if (seen) multi = 1'b1;
        seen = 1'b1;
        if (MODE == MergeOr) byte_out = byte_out | data[i*8 +: 8];
        else                 byte_out = data[i*8 +: 8];
      end
    end
  end

endmodule

// File: rtl/dcache_wdata_coalesce_pipe.sv
// Two-stage valid/ready store-data coalescer producing per-lane and per-block-word merged views.
module dcache_wdata_coalesce_pipe
  import dcache_wdata_coalesce_pipe_pkg::*;
#(
  parameter int unsigned NLANES     = dcache_wdata_coalesce_pipe_pkg::NLANES,
  parameter int unsigned OFFSETBITS = dcache_wdata_coalesce_pipe_pkg::OFFSETBITS,
  parameter int unsigned BYTES      = dcache_wdata_coalesce_pipe_pkg::BYTES,
  parameter int unsigned WORDLEN    = 8 * BYTES,
  parameter merge_mode_e MERGE_MODE = dcache_wdata_coalesce_pipe_pkg::MERGE_MODE
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   in_valid_i,
  output logic                                   in_ready_o,
  input  logic [NLANES-1:0]                      active_mask_i,
  input  logic [NLANES*OFFSETBITS-1:0]           block_offset_i,
  input  logic [NLANES*BYTES-1:0]                byte_mask_i,
  input  logic [NLANES*WORDLEN-1:0]              data_i,
  output logic                                   out_valid_o,
  input  logic                                   out_ready_i,
  output logic [NLANES*BYTES-1:0]                lane_mask_o,
  output logic [NLANES*WORDLEN-1:0]              lane_data_o,
  output logic [(1<<OFFSETBITS)*BYTES-1:0]       word_mask_o,
  output logic [(1<<OFFSETBITS)*WORDLEN-1:0]     word_data_o,
  output logic                                   conflict_o
);

  localparam int unsigned NW = 1 << OFFSETBITS;

  logic                           s1_valid, s2_valid, s1_adv, s2_adv;
  logic [NLANES-1:0]              s1_active;
  logic [NLANES*OFFSETBITS-1:0]   s1_off;
  logic [NLANES*BYTES-1:0]        s1_bmask;
  logic [NLANES*WORDLEN-1:0]      s1_data;
  logic [NLANES*NLANES-1:0]       s1_match, match_d;

  logic [NLANES*BYTES-1:0]        lane_mask_d, lane_multi;
  logic [NLANES*WORDLEN-1:0]      lane_data_d;
  logic [NW*BYTES-1:0]            word_mask_d, word_multi;
  logic [NW*WORDLEN-1:0]          word_data_d;

  assign s2_adv      = !s2_valid || out_ready_i;
  assign s1_adv      = !s1_valid || s2_adv;
  assign in_ready_o  = s1_adv;
  assign out_valid_o = s2_valid;

  always_comb begin
    match_d = '0;
    for (int unsigned n = 0; n < NLANES; n++) begin
      for (int unsigned m = 0; m < NLANES; m++) begin
        match_d[n*NLANES+m] = active_mask_i[n] && active_mask_i[m] &&
            (block_offset_i[n*OFFSETBITS +: OFFSETBITS] ==
             block_offset_i[m*OFFSETBITS +: OFFSETBITS]);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_active <= '0;
      s1_off    <= '0;
      s1_bmask  <= '0;
      s1_data   <= '0;
      s1_match  <= '0;
    end else if (s1_adv) begin
      s1_valid <= in_valid_i;
      if (in_valid_i) begin
        s1_active <= active_mask_i;
        s1_off    <= block_offset_i;
        s1_bmask  <= byte_mask_i;
        s1_data   <= data_i;
        s1_match  <= match_d;
      end
    end
  end

  for (genvar b = 0; b < BYTES; b++) begin : g_byte
    logic [NLANES*8-1:0] bdata;
    for (genvar m = 0; m < NLANES; m++) begin : g_gather
      assign bdata[m*8 +: 8] = s1_data[m*WORDLEN + b*8 +: 8];
    end

    for (genvar n = 0; n < NLANES; n++) begin : g_lane
      logic [NLANES-1:0] cand;
      for (genvar m = 0; m < NLANES; m++) begin : g_cand
        assign cand[m] = s1_match[n*NLANES+m] && s1_bmask[m*BYTES+b];
      end
      dcache_byte_prio_merge #(.N(NLANES), .MODE(MERGE_MODE)) u_merge (
        .cand     (cand),
        .data     (bdata),
        .hit      (lane_mask_d[n*BYTES+b]),
        .byte_out (lane_data_d[n*WORDLEN + b*8 +: 8]),
        .multi    (lane_multi[n*BYTES+b])
      );
    end

    for (genvar w = 0; w < NW; w++) begin : g_word
      logic [NLANES-1:0] cand;
      for (genvar m = 0; m < NLANES; m++) begin : g_cand
        assign cand[m] = s1_active[m] && s1_bmask[m*BYTES+b] &&
            (s1_off[m*OFFSETBITS +: OFFSETBITS] == OFFSETBITS'(w));
      end
      dcache_byte_prio_merge #(.N(NLANES), .MODE(MERGE_MODE)) u_merge (
        .cand     (cand),
        .data     (bdata),
        .hit      (word_mask_d[w*BYTES+b]),
        .byte_out (word_data_d[w*WORDLEN + b*8 +: 8]),
        .multi    (word_multi[w*BYTES+b])
      );
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid    <= 1'b0;
      lane_mask_o <= '0;
      lane_data_o <= '0;
      word_mask_o <= '0;
      word_data_o <= '0;
      conflict_o  <= 1'b0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        lane_mask_o <= lane_mask_d;
        lane_data_o <= lane_data_d;
        word_mask_o <= word_mask_d;
        word_data_o <= word_data_d;
        // Lane-view overlaps are a subset of word-view overlaps; OR-ing both is equivalent.
        conflict_o  <= (|word_multi) || (|lane_multi);
      end
    end
  end

endmodule
